decoder8_pulse: RTL and testbench

- Sequential 3-to-8 one-hot decoder. It is the inverse of the 8:3 one-hot encoder path.
- Accepts a command {code, length} over a valid/ready handshake and drives the one-hot line `1 << code` for exactly length+1 consecutive cycles, then idles.
- Sits upstream of the encoder, so an encoder fed from this block's `out` reproduces `code` while `valid` is high.
- Supports back-to-back commands with no idle gap.

---
 rtl/ddca_pkg.sv | 18 +
 rtl/decoder8.sv | 20 ++
 rtl/decoder8_pulse.sv | 91 +++++++++
 tb/tb_decoder8_pulse.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/ddca_pkg.sv
// ---------------------------------------------------------------------------
// ddca_pkg
// Shared types and widths for the one-hot decode/encode datapath.
//   dec_state_t : FSM state of the pulsed decoder (IDLE / DRIVE)
//   ONEHOT_W    : width of the one-hot line bus
//   CODE_W      : width of the binary line index
// ---------------------------------------------------------------------------
package ddca_pkg;

  localparam int ONEHOT_W = 8;
  localparam int CODE_W   = 3;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    DRIVE = 1'b1
  } dec_state_t;

endpackage : ddca_pkg

// File: rtl/decoder8.sv
// ---------------------------------------------------------------------------
// decoder8
// Pure combinational 3:8 one-hot decoder, the inverse of the 8:3 encoder.
// Ports:
//   code   : in  [CODE_W-1:0]   binary index of the line to raise
//   onehot : out [ONEHOT_W-1:0] exactly one bit set, bit 'code'
// ---------------------------------------------------------------------------
module decoder8
  import ddca_pkg::*;
(
  input  logic [CODE_W-1:0]   code,
  output logic [ONEHOT_W-1:0] onehot
);

  // One comparator per output line; every code value maps to a single line.
  for (genvar gi = 0; gi < ONEHOT_W; gi++) begin : g_line
    assign onehot[gi] = (code == CODE_W'(gi));
  end

endmodule : decoder8

// File: rtl/decoder8_pulse.sv
// ---------------------------------------------------------------------------
// decoder8_pulse
// Sequential 3-to-8 one-hot decoder. Accepts {code, length} over a
// valid/ready handshake and drives the line 1<<code for length+1 cycles.
// Back-to-back commands are accepted on the final drive cycle with no gap.
// Ports:
//   clk      : in  system clock, rising edge
//   rst      : in  asynchronous active-high reset
//   in_valid : in  command present
//   in_ready : out command can be accepted this cycle
//   in_code  : in  [2:0] line index to assert
//   in_len   : in  [LEN_W-1:0] hold length minus one
//   out      : out [7:0] one-hot line, all-zero when idle
//   valid    : out out holds a valid one-hot value
//   done     : out final drive cycle of a command
// ---------------------------------------------------------------------------
module decoder8_pulse
  import ddca_pkg::*;
#(
  parameter int LEN_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [CODE_W-1:0]   in_code,
  input  logic [LEN_W-1:0]    in_len,
  output logic [ONEHOT_W-1:0] out,
  output logic                valid,
  output logic                done
);

  dec_state_t            state_reg, state_next;
  logic [LEN_W-1:0]      cnt_reg, cnt_next;
  logic [ONEHOT_W-1:0]   out_reg, out_next;
  logic [ONEHOT_W-1:0]   decoded;
  logic                  last_cycle;
  logic                  xfer;

  decoder8 u_decoder8 (
    .code   (in_code),
    .onehot (decoded)
  );

  // Ready depends only on registered state, never on in_valid.
  assign last_cycle = (cnt_reg == '0);
  assign xfer       = in_valid && in_ready;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      out_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      out_reg   <= out_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    out_next   = out_reg;
    if (xfer) begin
      // Covers both IDLE capture and the gapless reload on the final cycle.
      state_next = DRIVE;
      cnt_next   = in_len;
      out_next   = decoded;
    end else if (state_reg == DRIVE) begin
      if (!last_cycle) begin
        cnt_next = cnt_reg - LEN_W'(1);
      end else begin
        // Clearing out_reg here keeps out all-zero whenever valid is low.
        state_next = IDLE;
        out_next   = '0;
      end
    end
  end

  // Output logic
  always_comb begin
    in_ready = (state_reg == IDLE) || last_cycle;
    valid    = (state_reg == DRIVE);
    done     = (state_reg == DRIVE) && last_cycle;
    out      = out_reg;
  end

endmodule : decoder8_pulse

// File: tb/tb_decoder8_pulse.sv
module tb_decoder8_pulse;

  localparam int LEN_W = 4;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_code;
  logic [LEN_W-1:0] in_len;
  logic [7:0]       out;
  logic             valid;
  logic             done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] line;
    logic [2:0] code;
    logic       last;
  } exp_t;

  exp_t sb[$];

  decoder8_pulse #(.LEN_W(LEN_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_code  (in_code),
    .in_len   (in_len),
    .out      (out),
    .valid    (valid),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference 8:3 encoder for the round-trip check.
  function automatic logic [2:0] enc8(input logic [7:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < 8; i++) if (v[i]) r = 3'(i);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Compare outputs against the scoreboard head (or idle if empty).
  task automatic check_out(input string tag);
    if (sb.size() > 0) begin
      chk({tag, ".out"},   {24'd0, out}, {24'd0, sb[0].line});
      chk({tag, ".valid"}, {31'd0, valid}, 32'd1);
      chk({tag, ".done"},  {31'd0, done}, {31'd0, sb[0].last});
      chk({tag, ".enc"},   {29'd0, enc8(out)}, {29'd0, sb[0].code});
      chk({tag, ".oh"},    {31'd0, $onehot(out)}, 32'd1);
    end else begin
      chk({tag, ".out"},   {24'd0, out}, 32'd0);
      chk({tag, ".valid"}, {31'd0, valid}, 32'd0);
      chk({tag, ".done"},  {31'd0, done}, 32'd0);
    end
    $display("%0t %s out=%02h valid=%0d done=%0d ready=%0d", $time, tag, out, valid, done, in_ready);
  endtask

  // One clock cycle: drive inputs, check ready, clock, update model, check.
  task automatic cycle(input string tag, input logic v, input logic [2:0] c,
                       input logic [LEN_W-1:0] l);
    logic exp_ready;
    logic x;
    in_valid = v;
    in_code  = c;
    in_len   = l;
    #1;
    exp_ready = (sb.size() == 0) || sb[0].last;
    chk({tag, ".ready"}, {31'd0, in_ready}, {31'd0, exp_ready});
    x = v && exp_ready;
    @(posedge clk);
    if (sb.size() > 0) void'(sb.pop_front());
    if (x) begin
      for (int k = 0; k <= int'(l); k++) begin
        exp_t e;
        e.line = 8'h01 << c;
        e.code = c;
        e.last = (k == int'(l));
        sb.push_back(e);
      end
    end
    #1;
    check_out(tag);
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_code  = 3'd0;
    in_len   = '0;
    #12;
    check_out("reset");
    chk("reset.ready", {31'd0, in_ready}, 32'd1);
    rst = 1'b0;

    cycle("idle", 1'b0, 3'd0, 4'd0);

    // Single-cycle pulse
    cycle("single", 1'b1, 3'd3, 4'd0);
    cycle("single_end", 1'b0, 3'd0, 4'd0);
    cycle("idle", 1'b0, 3'd0, 4'd0);

    // Multi-cycle hold
    cycle("hold", 1'b1, 3'd7, 4'd4);
    for (int i = 0; i < 5; i++) cycle("hold", 1'b0, 3'd0, 4'd0);

    // Back-to-back with in_valid held
    cycle("b2b", 1'b1, 3'd0, 4'd1);
    cycle("b2b", 1'b1, 3'd5, 4'd2);
    cycle("b2b", 1'b1, 3'd5, 4'd2);
    for (int i = 0; i < 3; i++) cycle("b2b", 1'b0, 3'd0, 4'd0);

    // Backpressure: changing codes while busy must be ignored
    cycle("bp", 1'b1, 3'd1, 4'd5);
    for (int i = 0; i < 6; i++) cycle("bp", 1'b1, 3'(i + 2), 4'd0);
    cycle("bp", 1'b0, 3'd0, 4'd0);
    cycle("bp", 1'b0, 3'd0, 4'd0);

    // Maximum length
    cycle("max", 1'b1, 3'd6, 4'd15);
    for (int i = 0; i < 17; i++) cycle("max", 1'b0, 3'd0, 4'd0);

    // Round-trip sweep, back-to-back across all codes
    for (int c = 0; c < 8; c++) begin
      cycle("sweep", 1'b1, 3'(c), 4'(c % 3));
      for (int k = 0; k < c % 3; k++) cycle("sweep", 1'b0, 3'd0, 4'd0);
    end
    cycle("sweep", 1'b0, 3'd0, 4'd0);
    cycle("sweep", 1'b0, 3'd0, 4'd0);

    // Asynchronous reset mid-command
    cycle("abort", 1'b1, 3'd4, 4'd9);
    cycle("abort", 1'b0, 3'd0, 4'd0);
    #2;
    rst = 1'b1;
    #1;
    sb.delete();
    check_out("abort_rst");
    chk("abort_rst.ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    check_out("abort_hold");
    rst = 1'b0;
    for (int i = 0; i < 3; i++) cycle("post_rst", 1'b0, 3'd0, 4'd0);
    cycle("post_rst", 1'b1, 3'd2, 4'd1);
    for (int i = 0; i < 3; i++) cycle("post_rst", 1'b0, 3'd0, 4'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_decoder8_pulse
